ofm_serializer: RTL and testbench

Converts the lane-parallel output vectors of a 1x1 convolution layer (LANES channels of one pixel, delivered as a one-cycle pulse) into the one-value-per-cycle ifm stream that the next convolution layer consumes. A two-bank ping-pong vector buffer lets the producing layer deliver the next pixel while the current pixel is being streamed out. It sits between a conv layer's `ofm` array and the following layer's `ifm` input, and counts pixels to flag layer completion.

---
 rtl/ofm_serializer_pkg.sv | 20 ++
 rtl/ofm_serializer_if.sv | 27 ++
 rtl/ofm_serializer_pingpong_vec_buf.sv | 63 ++++++
 rtl/ofm_serializer.sv | 136 +++++++++++++
 tb/tb_ofm_serializer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_serializer_pkg.sv
// Shared definitions for the layer output serializers: default geometry,
// the serializer FSM state encoding and a counter-width helper.
package ofm_serializer_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int LANES_DEF  = 512;
    localparam int PIXELS_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } ser_state_e;

    // Width of a counter indexing 0..n-1 (never narrower than one bit).
    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ofm_serializer_if.sv
// Vector-in / value-out bus between a conv layer's ofm array and the
// next layer's ifm input. The serializer takes the slave side.
interface ofm_serializer_if
    import ofm_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF
);
    logic                          vec_valid;
    logic [0:LANES-1][WIDTH-1:0]   vec_data;
    logic                          vec_ready;
    logic                          out_valid;
    logic [WIDTH-1:0]              out_data;
    logic                          out_ready;
    logic                          out_last_ch;
    logic                          out_last;

    modport master (
        output vec_valid, vec_data, out_ready,
        input  vec_ready, out_valid, out_data, out_last_ch, out_last
    );

    modport slave (
        input  vec_valid, vec_data, out_ready,
        output vec_ready, out_valid, out_data, out_last_ch, out_last
    );
endinterface

// File: rtl/ofm_serializer_pingpong_vec_buf.sv
// Two-bank ping-pong buffer holding whole lane vectors. One bank can be
// filled while the other is read out lane by lane.
module pingpong_vec_buf
    import ofm_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF,
    parameter int LW    = cnt_bits(LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [0:LANES-1][WIDTH-1:0] wr_data,
    input  logic                        rd_release,
    input  logic [LW-1:0]               rd_lane,
    output logic [WIDTH-1:0]            rd_data,
    output logic [1:0]                  count,
    output logic                        free,
    output logic                        can_accept
);
    logic [0:LANES-1][WIDTH-1:0] bank_mem [0:1];
    logic                        wr_bank_reg;
    logic                        rd_bank_reg;
    logic [1:0]                  count_reg;

    assign count   = count_reg;
    assign free    = (count_reg != 2'd2);
    // A full buffer still accepts when the read bank is being released this
    // cycle: the released bank is read combinationally now and overwritten
    // at the edge, so the last lane is never corrupted.
    assign can_accept = free || rd_release;
    assign rd_data = bank_mem[rd_bank_reg][rd_lane];

    // Bank contents: whole-vector write, no reset needed on data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[wr_bank_reg] <= wr_data;
        end
    end

    // Bank pointers and occupancy; capture and release may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            count_reg   <= 2'd0;
        end else if (clear) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            count_reg   <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (rd_release) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
            count_reg <= count_reg + {1'b0, wr_en} - {1'b0, rd_release};
        end
    end

endmodule

// File: rtl/ofm_serializer.sv
// Serializes lane-parallel conv output vectors into a one-value-per-cycle
// ifm stream, counting pixels to flag the end of a layer.
module ofm_serializer
    import ofm_serializer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int PIXELS = PIXELS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    ofm_serializer_if.slave    bus,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    localparam int LW  = cnt_bits(LANES);
    localparam int PW  = cnt_bits(PIXELS);
    localparam int PIW = $clog2(PIXELS + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_STREAM = STREAM;
    localparam logic [1:0] ST_DONE   = DONE;

    logic [1:0]       state_reg;
    logic [LW-1:0]    lane_reg;
    logic [PW-1:0]    pixel_reg;
    logic [PIW-1:0]   pix_in_reg;
    logic             done_reg;
    logic             overflow_reg;

    logic             stream;
    logic             out_valid;
    logic             transfer;
    logic             lane_last;
    logic             pix_last;
    logic             release_vec;
    logic             layer_end;
    logic             capture;
    logic             drop;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       buf_count;
    logic             buf_free;
    logic             buf_can_accept;

    assign stream      = (state_reg == ST_STREAM);
    assign out_valid   = stream && (buf_count != 2'd0);
    assign transfer    = out_valid && bus.out_ready;
    assign lane_last   = (lane_reg == LW'(LANES - 1));
    assign pix_last    = (pixel_reg == PW'(PIXELS - 1));
    assign release_vec = transfer && lane_last;
    assign layer_end   = release_vec && pix_last;
    assign capture     = stream && !start && bus.vec_valid && buf_can_accept
                         && (pix_in_reg < PIW'(PIXELS));
    assign drop        = bus.vec_valid && !capture && !start;

    assign bus.vec_ready   = stream && buf_free;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? rd_data : '0;
    assign bus.out_last_ch = out_valid && lane_last;
    assign bus.out_last    = out_valid && lane_last && pix_last;
    assign busy            = stream;
    assign done            = done_reg;
    assign overflow        = overflow_reg;

    pingpong_vec_buf #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .LW    (LW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .wr_en      (capture),
        .wr_data    (bus.vec_data),
        .rd_release (release_vec),
        .rd_lane    (lane_reg),
        .rd_data    (rd_data),
        .count      (buf_count),
        .free       (buf_free),
        .can_accept (buf_can_accept)
    );

    // Layer FSM: start always (re)enters STREAM, final transfer ends it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else if (start) begin
            state_reg <= ST_STREAM;
        end else if (stream && layer_end) begin
            state_reg <= ST_DONE;
        end
    end

    // Lane, output-pixel and accepted-vector counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_reg   <= '0;
            pixel_reg  <= '0;
            pix_in_reg <= '0;
        end else if (start) begin
            lane_reg   <= '0;
            pixel_reg  <= '0;
            pix_in_reg <= '0;
        end else begin
            if (transfer) begin
                lane_reg <= lane_last ? '0 : lane_reg + LW'(1);
            end
            // The last pixel holds its index; DONE is entered instead of wrapping.
            if (release_vec && !pix_last) begin
                pixel_reg <= pixel_reg + PW'(1);
            end
            if (capture) begin
                pix_in_reg <= pix_in_reg + PIW'(1);
            end
        end
    end

    // Completion pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (start) begin
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            done_reg <= stream && layer_end;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofm_serializer.sv
// Directed bench for ofm_serializer with a queue scoreboard and a monitor
// that checks every accepted output value.
module tb_ofm_serializer;
    import ofm_serializer_pkg::*;

    localparam int LANES  = 512;
    localparam int WIDTH  = 16;
    localparam int PIXELS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, overflow;

    ofm_serializer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    ofm_serializer #(.WIDTH(WIDTH), .LANES(LANES), .PIXELS(PIXELS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last_ch;
        logic             last;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    int               xfer_cnt = 0;
    logic             hold_pending = 1'b0;
    logic [WIDTH-1:0] hold_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on every transfer, check data holds while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) check("hold_data", 32'(bus.out_data), 32'(hold_val));
            if (bus.out_valid && bus.out_ready) begin
                xfer_cnt <= xfer_cnt + 1;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got data %0d, expected no transfer", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(mon_e.data));
                    check("out_last_ch", 32'(bus.out_last_ch), 32'(mon_e.last_ch));
                    check("out_last", 32'(bus.out_last), 32'(mon_e.last));
                end
            end
            hold_pending <= bus.out_valid && !bus.out_ready;
            hold_val     <= bus.out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pulse one vector (lane i = tag*1000 + i + 1); queue it if it should be accepted.
    task automatic pulse_vec(input int tag, input bit accept, input bit last_layer);
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            bus.vec_data[i] = WIDTH'(tag * 1000 + i + 1);
            if (accept) begin
                e.data    = WIDTH'(tag * 1000 + i + 1);
                e.last_ch = (i == LANES - 1);
                e.last    = last_layer && (i == LANES - 1);
                exp_q.push_back(e);
            end
        end
        bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget, output int took);
        int c0;
        int n;
        c0 = cyc;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        took = cyc - c0;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d values still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!bus.vec_ready && n < budget) begin
            tick();
            n++;
        end
        if (!bus.vec_ready) begin
            tests++;
            fails++;
            $display("FAIL vec_ready_timeout: got vec_ready 0, expected 1 within %0d cycles", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int took;
        int c0;
        int x0;
        int n;
        int k;
        logic ready_seen;

        bus.vec_valid = 1'b0;
        bus.vec_data  = '0;
        bus.out_ready = 1'b1;

        // Reset values
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_vec_ready", 32'(bus.vec_ready), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_last_ch", 32'(bus.out_last_ch), 0);
        check("rst_out_last", 32'(bus.out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b1;
        tick();

        // Single vector, values 1..512, one-cycle latency
        do_start();
        check("t1_busy", 32'(busy), 1);
        check("t1_vec_ready", 32'(bus.vec_ready), 1);
        check("t1_out_valid_empty", 32'(bus.out_valid), 0);
        pulse_vec(0, 1'b1, 1'b0);
        check("t1_latency_valid", 32'(bus.out_valid), 1);
        check("t1_latency_data", 32'(bus.out_data), 1);
        drain("t1", 2000, took);
        check("t1_stream_cycles", 32'(took), 512);
        check("t1_out_valid_after", 32'(bus.out_valid), 0);

        // Three vectors ten cycles apart: third dropped
        do_start();
        pulse_vec(1, 1'b1, 1'b0);
        repeat (9) tick();
        pulse_vec(2, 1'b1, 1'b0);
        check("t2_ready_full", 32'(bus.vec_ready), 0);
        repeat (9) tick();
        pulse_vec(3, 1'b0, 1'b0);
        check("t2_overflow", 32'(overflow), 1);
        ready_seen = 1'b0;
        n = 0;
        while (exp_q.size() > 512 && n < 2000) begin
            ready_seen = ready_seen | bus.vec_ready;
            tick();
            n++;
        end
        check("t2_ready_low_while_full", 32'(ready_seen), 0);
        check("t2_ready_after_release", 32'(bus.vec_ready), 1);
        drain("t2", 2000, took);
        check("t2_overflow_sticky", 32'(overflow), 1);

        // Capture in the exact cycle the full buffer releases lane 511
        do_start();
        check("t3_overflow_cleared", 32'(overflow), 0);
        pulse_vec(4, 1'b1, 1'b0);
        c0 = cyc;
        pulse_vec(5, 1'b1, 1'b0);
        n = 0;
        while (exp_q.size() > 513 && n < 2000) begin
            tick();
            n++;
        end
        check("t3_ready_full", 32'(bus.vec_ready), 0);
        pulse_vec(6, 1'b1, 1'b0);
        check("t3_no_drop", 32'(overflow), 0);
        check("t3_still_full", 32'(bus.vec_ready), 0);
        drain("t3", 3000, took);
        check("t3_no_bubble_cycles", 32'(cyc - c0), 1536);

        // out_ready toggling every cycle
        do_start();
        pulse_vec(7, 1'b1, 1'b0);
        c0 = cyc;
        bus.out_ready = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 1200) begin
            tick();
            bus.out_ready = ~bus.out_ready;
            n++;
        end
        check("t4_toggle_cycles", 32'(cyc - c0), 1024);
        check("t4_drained", 32'(exp_q.size()), 0);
        exp_q.delete();
        bus.out_ready = 1'b1;

        // Full layer of 64 vectors
        do_start();
        x0 = xfer_cnt;
        for (int p = 0; p < PIXELS; p++) begin
            wait_ready(1200);
            pulse_vec(p, 1'b1, p == PIXELS - 1);
        end
        drain("t5", 2000, took);
        check("t5_transfers", 32'(xfer_cnt - x0), 32768);
        check("t5_done_pulse", 32'(done), 1);
        check("t5_busy_low", 32'(busy), 0);
        check("t5_ready_low", 32'(bus.vec_ready), 0);
        tick();
        check("t5_done_one_cycle", 32'(done), 0);
        check("t5_no_overflow_yet", 32'(overflow), 0);
        pulse_vec(11, 1'b0, 1'b0);
        check("t5_late_overflow", 32'(overflow), 1);

        // Asynchronous reset at lane 200 of pixel 5
        do_start();
        x0 = xfer_cnt;
        k = 0;
        n = 0;
        while ((xfer_cnt - x0) < (5 * 512 + 200) && n < 5000) begin
            if (bus.vec_ready && k < 8) begin
                pulse_vec(20 + k, 1'b1, 1'b0);
                k++;
            end else begin
                tick();
            end
            n++;
        end
        check("t6_pre_reset_data", 32'(bus.out_data), 25201);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_out_valid", 32'(bus.out_valid), 0);
        check("t6_rst_out_data", 32'(bus.out_data), 0);
        check("t6_rst_out_last_ch", 32'(bus.out_last_ch), 0);
        check("t6_rst_vec_ready", 32'(bus.vec_ready), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_overflow", 32'(overflow), 0);
        tick();
        rst = 1'b1;
        tick();
        check("t6_idle_after_rst", 32'(busy), 0);
        do_start();
        pulse_vec(9, 1'b1, 1'b0);
        check("t6_fresh_lane0", 32'(bus.out_data), 9001);
        drain("t6", 2000, took);
        check("t6_fresh_cycles", 32'(took), 512);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
